pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage WISC-SP20 core. Merges decode hazard

---
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: turns hazard, memory-busy and halt
// requests into pipe-register enables, bubble/flush controls and PC write enable.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_decode,
    input  logic             flush_fetch,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_id,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             en_ex_mem,
    output logic             en_mem_wb,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_en        = 1'b0;
        en_if_id     = 1'b0;
        en_id_ex     = 1'b0;
        en_ex_mem    = 1'b0;
        en_mem_wb    = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        halted       = 1'b0;
        case (state)
            S_INIT: begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                state_next   = S_RUN;
            end
            S_RUN: begin
                pc_en     = 1'b1;
                en_if_id  = 1'b1;
                en_id_ex  = 1'b1;
                en_ex_mem = 1'b1;
                en_mem_wb = 1'b1;
                // Requests resolve in strict priority; a redirect outranks decode stalls and halts
                if (dmem_stall) begin
                    pc_en     = 1'b0;
                    en_if_id  = 1'b0;
                    en_id_ex  = 1'b0;
                    en_ex_mem = 1'b0;
                    en_mem_wb = 1'b0;
                end else if (flush_fetch) begin
                    flush_if_id = 1'b1;
                end else if (stall_decode) begin
                    pc_en        = 1'b0;
                    en_if_id     = 1'b0;
                    bubble_id_ex = 1'b1;
                end else if (halt_id) begin
                    pc_en       = 1'b0;
                    flush_if_id = 1'b1;
                    state_next  = S_DRAIN;
                end else if (imem_stall) begin
                    pc_en       = 1'b0;
                    flush_if_id = 1'b1;
                end
                if (halt_wb) begin
                    state_next = S_HALTED;
                end
            end
            S_DRAIN: begin
                en_if_id    = 1'b1;
                flush_if_id = 1'b1;
                en_id_ex    = !dmem_stall;
                en_ex_mem   = !dmem_stall;
                en_mem_wb   = !dmem_stall;
                if (halt_wb) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // Performance counters only advance in RUN and stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state == S_RUN) begin
            if (!pc_en && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_if_id && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl against a behavioural model of
// the sequencing rules; a second instance with 4-bit counters covers saturation.
module tb_pipe_ctrl;

    localparam int PH_INIT   = 0;
    localparam int PH_RUN    = 1;
    localparam int PH_DRAIN  = 2;
    localparam int PH_HALTED = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic stall_decode, flush_fetch, imem_stall, dmem_stall, halt_id, halt_wb;

    logic pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, bubble_id_ex, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_en_if_id, s_en_id_ex, s_en_ex_mem, s_en_mem_wb;
    logic s_flush_if_id, s_bubble_id_ex, s_halted;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_stall, m_flush, m_stall_s, m_flush_s;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .stall_decode(stall_decode), .flush_fetch(flush_fetch), .imem_stall(imem_stall),
        .dmem_stall(dmem_stall), .halt_id(halt_id), .halt_wb(halt_wb),
        .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
        .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst_n(rst_n),
        .stall_decode(stall_decode), .flush_fetch(flush_fetch), .imem_stall(imem_stall),
        .dmem_stall(dmem_stall), .halt_id(halt_id), .halt_wb(halt_wb),
        .pc_en(s_pc_en), .en_if_id(s_en_if_id), .en_id_ex(s_en_id_ex), .en_ex_mem(s_en_ex_mem),
        .en_mem_wb(s_en_mem_wb), .flush_if_id(s_flush_if_id), .bubble_id_ex(s_bubble_id_ex),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, bubble_id_ex, halted}
    function automatic logic [7:0] modelOutputs(input int phase, input logic dm, input logic ff,
                                                input logic sd, input logic hi, input logic im);
        logic [7:0] v;
        case (phase)
            PH_INIT:   v = 8'b0_0000_110;
            PH_HALTED: v = 8'b0_0000_001;
            PH_DRAIN:  v = dm ? 8'b0_1000_100 : 8'b0_1111_100;
            default: begin
                if (dm)      v = 8'b0_0000_000;
                else if (ff) v = 8'b1_1111_100;
                else if (sd) v = 8'b0_0111_010;
                else if (hi) v = 8'b0_1111_100;
                else if (im) v = 8'b0_1111_100;
                else         v = 8'b1_1111_000;
            end
        endcase
        return v;
    endfunction

    function automatic int satInc(input int value, input int maxValue);
        return (value < maxValue) ? value + 1 : value;
    endfunction

    task automatic checkAll(input string tag, input logic [7:0] expCtl);
        checkOutput({tag, "_ctl"}, {24'd0, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                                    flush_if_id, bubble_id_ex, halted}, {24'd0, expCtl});
        checkOutput({tag, "_ctl_small"}, {24'd0, s_pc_en, s_en_if_id, s_en_id_ex, s_en_ex_mem,
                                          s_en_mem_wb, s_flush_if_id, s_bubble_id_ex, s_halted},
                    {24'd0, expCtl});
        checkOutput({tag, "_stall_cnt"}, {16'd0, stall_cnt}, m_stall);
        checkOutput({tag, "_flush_cnt"}, {16'd0, flush_cnt}, m_flush);
        checkOutput({tag, "_stall_cnt_small"}, {28'd0, s_stall_cnt}, m_stall_s);
        checkOutput({tag, "_flush_cnt_small"}, {28'd0, s_flush_cnt}, m_flush_s);
    endtask

    task automatic modelReset();
        m_phase   = PH_INIT;
        m_stall   = 0;
        m_flush   = 0;
        m_stall_s = 0;
        m_flush_s = 0;
    endtask

    // One clock: drive at negedge, check mid-cycle, advance the model at posedge
    task automatic applyStimulus(input string tag, input logic dm, input logic ff, input logic sd,
                                 input logic hi, input logic im, input logic hw);
        logic [7:0] expCtl;
        @(negedge clk);
        dmem_stall   = dm;
        flush_fetch  = ff;
        stall_decode = sd;
        halt_id      = hi;
        imem_stall   = im;
        halt_wb      = hw;
        #1;
        expCtl = modelOutputs(m_phase, dm, ff, sd, hi, im);
        checkAll(tag, expCtl);
        @(posedge clk);
        case (m_phase)
            PH_INIT: m_phase = PH_RUN;
            PH_RUN: begin
                if (!expCtl[7]) begin
                    m_stall   = satInc(m_stall, 65535);
                    m_stall_s = satInc(m_stall_s, 15);
                end
                if (expCtl[2]) begin
                    m_flush   = satInc(m_flush, 65535);
                    m_flush_s = satInc(m_flush_s, 15);
                end
                if (hw)
                    m_phase = PH_HALTED;
                else if (!dm && !ff && !sd && hi)
                    m_phase = PH_DRAIN;
            end
            PH_DRAIN: if (hw) m_phase = PH_HALTED;
            default: m_phase = m_phase;
        endcase
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        rst_n        = 1'b0;
        dmem_stall   = 1'b0;
        flush_fetch  = 1'b0;
        stall_decode = 1'b0;
        halt_id      = 1'b0;
        imem_stall   = 1'b0;
        halt_wb      = 1'b0;
        modelReset();
        #1;
        checkAll(tag, modelOutputs(PH_INIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic applyRandom(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(99) < 2) begin
                doReset("rnd_reset");
            end else begin
                applyStimulus("rnd",
                              $urandom_range(99) < 15, $urandom_range(99) < 15,
                              $urandom_range(99) < 20, $urandom_range(99) < 6,
                              $urandom_range(99) < 20, $urandom_range(99) < 4);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        {stall_decode, flush_fetch, imem_stall, dmem_stall, halt_id, halt_wb} = '0;
        modelReset();

        doReset("por");
        applyStimulus("t1_init", 0, 0, 0, 0, 0, 0);
        applyRandom(10);

        // Mid-run reset returns to one INIT cycle then full-enable RUN
        doReset("t1_reset");
        applyStimulus("t1_init2", 0, 0, 0, 0, 0, 0);
        applyStimulus("t1_run", 0, 0, 0, 0, 0, 0);

        doReset("t2_reset");
        applyStimulus("t2_init", 0, 0, 0, 0, 0, 0);
        applyStimulus("t2_stall", 0, 0, 1, 0, 0, 0);
        applyStimulus("t2_stall", 0, 0, 1, 0, 0, 0);
        #1 checkOutput("t2_stall_cnt_abs", {16'd0, stall_cnt}, 32'd2);

        doReset("t3_reset");
        applyStimulus("t3_init", 0, 0, 0, 0, 0, 0);
        applyStimulus("t3_redirect", 0, 1, 1, 1, 0, 0);
        applyStimulus("t3_after", 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t3_flush_cnt_abs", {16'd0, flush_cnt}, 32'd1);
        checkOutput("t3_stall_cnt_abs", {16'd0, stall_cnt}, 32'd0);
        checkOutput("t3_still_running", {31'd0, pc_en}, 32'd1);

        doReset("t4_reset");
        applyStimulus("t4_init", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus("t4_freeze", 1, 1, 0, 0, 0, 0);
        applyStimulus("t4_redirect", 0, 1, 0, 0, 1, 0);
        #1;
        checkOutput("t4_stall_cnt_abs", {16'd0, stall_cnt}, 32'd3);
        checkOutput("t4_flush_cnt_abs", {16'd0, flush_cnt}, 32'd1);

        doReset("t5_reset");
        applyStimulus("t5_init", 0, 0, 0, 0, 0, 0);
        applyStimulus("t5_halt_id", 0, 0, 0, 1, 0, 0);
        applyStimulus("t5_drain", 0, 1, 1, 0, 0, 0);
        applyStimulus("t5_drain_dmem", 1, 0, 0, 0, 0, 0);
        applyStimulus("t5_drain", 0, 0, 0, 0, 1, 0);
        applyStimulus("t5_halt_wb", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus("t5_halted", $urandom_range(1), $urandom_range(1), $urandom_range(1),
                          $urandom_range(1), $urandom_range(1), $urandom_range(1));
        #1 checkOutput("t5_halted_abs", {31'd0, halted}, 32'd1);

        doReset("t6_reset");
        applyStimulus("t6_init", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus("t6_stall", 0, 0, 1, 0, 0, 0);
        #1;
        checkOutput("t6_small_sat", {28'd0, s_stall_cnt}, 32'd15);
        checkOutput("t6_wide_count", {16'd0, stall_cnt}, 32'd20);

        doReset("rnd_start");
        applyRandom(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
